stream_demux_n: RTL and testbench
=================================

Name: stream_demux_n

Overview:
- Parametrised, registered 1-to-N stream demultiplexer. It is the clocked, handshaked successor of the fixed 3-to-8 one-hot demux.
- Routes each accepted input word to the output channel chosen by its select field.
- Each channel has a one-deep holding register and an independent valid/ready handshake.
- Sits between a single producer and N consumer lanes. Out-of-range selects are dropped and counted.

Parameters:
- N_CH, 8, number of output channels; range 2..64, not required to be a power of 2.
- DW, 8, data width in bits; range 1..256.
- SW, $clog2(N_CH), select width. Derived localparam, not overridable.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronised externally to clk.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can consume the input word this cycle.
- s_sel  in  SW  destination channel index.
- s_data  in  DW  input word.
- m_valid  out  N_CH  per-channel output valid.
- m_ready  in  N_CH  per-channel consumer ready.
- m_data  out  N_CH*DW  per-channel data; channel i occupies bits [i*DW +: DW].
- last_onehot  out  N_CH  one-hot of the most recent in-range channel loaded.
- drop_pulse  out  1  one-cycle pulse when an out-of-range word is consumed.
- drop_cnt  out  CNT_W  saturating count of dropped words.

Behaviour:
- Reset values: m_valid=0, m_data=0, last_onehot=0, drop_pulse=0, drop_cnt=0. s_ready is combinational and follows the rule below after reset.
- in_range = (s_sel < N_CH).
- s_ready = in_range ? (!m_valid[s_sel] || m_ready[s_sel]) : 1. Out-of-range words are always consumed, never stall.
- s_ready depends combinationally on s_sel, m_valid and m_ready. No dependence on s_valid.
- Accept = s_valid && s_ready.
- Latency: a word accepted in cycle t appears on m_valid/m_data of its channel in cycle t+1.
- Throughput: 1 word/cycle when consumers are ready.
- Per channel i, evaluated every cycle; priority order:
  - load (accept && in_range && s_sel==i): m_valid[i]<=1, m_data[i]<=s_data.
  - else drain (m_valid[i] && m_ready[i]): m_valid[i]<=0. m_data[i] holds its last value.
  - else hold.
- Simultaneous drain and load on the same channel: load wins, m_valid stays 1, the new data replaces the old in that cycle. No bubble, no loss.
- Channels are fully independent. A stalled channel never blocks words destined for other channels.
- m_data[i] is stable while m_valid[i]=1 and m_ready[i]=0 (AXI-style hold).
- last_onehot <= (1<<s_sel) on each in-range accept; otherwise it holds.
- Out-of-range accept: drop_pulse<=1 for exactly one cycle. drop_cnt increments, saturating at all-ones, with no wrap. No channel state changes.
- s_valid=0: no state change except drains. drop_pulse<=0.
- Reset mid-operation: all held words are discarded immediately; no partial transfers survive.
- Inputs are X-free when s_valid=1. s_sel and s_data are don't-care when s_valid=0.

Decomposition:
- Package stream_demux_pkg holds:
  - default N_CH/DW constants;
  - function sel_to_onehot(sel, n), shared with the combinational demux family;
  - a ch_state_t struct {valid, data} for bench and RTL.
- One sub-module, demux_ch_reg: a single-channel holding register implementing load/drain/hold. Instantiated N_CH times in a generate loop.
- The top level contains select decode, s_ready mux, drop logic and last_onehot.

Test Plan:
- Reset, then stream sel=0..7 with data 8'h10..8'h17, all m_ready=1. Each word appears on its channel one cycle later, m_valid pulses once per channel, and last_onehot ends at 8'h80.
- Hold m_ready[3]=0, send sel=3 data 8'hA5, then sel=3 data 8'h5A. The first word loads, s_ready drops to 0 for the second, and m_data[3] stays 8'hA5. Raise m_ready[3]: in the same cycle the second word is accepted, and the next cycle m_data[3]=8'h5A with m_valid[3] still 1.
- With channel 3 stalled, send sel=5 data 8'h33. It is accepted immediately and appears on channel 5 one cycle later (no head-of-line blocking).
- N_CH=6, send sel=6 then sel=7. s_ready=1 both cycles, drop_pulse=1 in each following cycle, drop_cnt=2, and no m_valid asserts.
- CNT_W=2, send 5 out-of-range words. drop_cnt reads 1,2,3,3,3 (saturates).
- Load channels 1 and 2, assert rst_n=0 asynchronously mid-cycle. m_valid, last_onehot and drop_cnt go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer family.
// The one-hot decoder is also used by the combinational demux variants.
package stream_demux_pkg;

    localparam int DEF_N_CH = 8;
    localparam int DEF_DW   = 8;
    localparam int MAX_CH   = 64;

    typedef struct packed {
        logic              valid;
        logic [DEF_DW-1:0] data;
    } ch_state_t;

    // Returns all-zeros for an out-of-range select so callers can gate loads directly.
    function automatic logic [MAX_CH-1:0] sel_to_onehot(input int unsigned sel,
                                                       input int unsigned n);
        logic [MAX_CH-1:0] oh;
        oh = '0;
        if ((sel < n) && (sel < MAX_CH)) begin
            oh = 64'(1) << sel;
        end
        return oh;
    endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// One-deep holding register for a single output lane with valid/ready handshake.
// A load in the same cycle as a drain wins, so a busy lane sustains one word per cycle.
module demux_ch_reg
    import stream_demux_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with per-lane holding registers.
// Out-of-range selects are always consumed, pulsed on drop_pulse and counted.
module stream_demux_n
    import stream_demux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int DW    = DEF_DW,
    parameter int CNT_W = 16,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SW-1:0]      s_sel,
    input  logic [DW-1:0]      s_data,
    output logic [N_CH-1:0]    m_valid,
    input  logic [N_CH-1:0]    m_ready,
    output logic [N_CH*DW-1:0] m_data,
    output logic [N_CH-1:0]    last_onehot,
    output logic               drop_pulse,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int SEL_SPAN = 1 << SW;

    logic                in_range;
    logic [N_CH-1:0]     sel_oh;
    logic [N_CH-1:0]     ch_free;
    logic [SEL_SPAN-1:0] free_span;
    logic                accept;
    logic                drop;
    logic [N_CH-1:0]     load_vec;

    logic [N_CH-1:0]  last_onehot_q;
    logic [N_CH-1:0]  last_onehot_d;
    logic             drop_pulse_q;
    logic             drop_pulse_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    // free_span pads ch_free to the full select space so every s_sel value indexes a real bit.
    always_comb begin
        in_range  = (32'(s_sel) < 32'(N_CH));
        sel_oh    = N_CH'(sel_to_onehot(32'(s_sel), N_CH));
        ch_free   = ~m_valid | m_ready;
        free_span = SEL_SPAN'(ch_free);
        s_ready   = in_range ? free_span[s_sel] : 1'b1;
        accept    = s_valid & s_ready;
        drop      = accept & ~in_range;
        load_vec  = accept ? sel_oh : '0;
    end

    always_comb begin
        last_onehot_d = last_onehot_q;
        drop_pulse_d  = drop;
        drop_cnt_d    = drop_cnt_q;
        if (accept && in_range) begin
            last_onehot_d = sel_oh;
        end
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_onehot_q <= '0;
            drop_pulse_q  <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            last_onehot_q <= last_onehot_d;
            drop_pulse_q  <= drop_pulse_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign last_onehot = last_onehot_q;
    assign drop_pulse  = drop_pulse_q;
    assign drop_cnt    = drop_cnt_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        demux_ch_reg #(
            .DW(DW)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_vec[i]),
            .load_data(s_data),
            .ready    (m_ready[i]),
            .valid    (m_valid[i]),
            .data     (m_data[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: routing, stalls, drops, counter saturation, async reset.
module tb_stream_demux_n;
    import stream_demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 8 lanes, power-of-two select space
    logic        a_s_valid, a_s_ready, a_drop_pulse;
    logic [2:0]  a_s_sel;
    logic [7:0]  a_s_data, a_m_valid, a_m_ready, a_last;
    logic [63:0] a_m_data;
    logic [15:0] a_drop_cnt;

    // Instance B: 6 lanes, selects 6 and 7 are out of range
    logic        b_s_valid, b_s_ready, b_drop_pulse;
    logic [2:0]  b_s_sel;
    logic [7:0]  b_s_data;
    logic [5:0]  b_m_valid, b_m_ready, b_last;
    logic [47:0] b_m_data;
    logic [15:0] b_drop_cnt;

    // Instance C: 6 lanes, 2-bit drop counter
    logic        c_s_valid, c_s_ready, c_drop_pulse;
    logic [2:0]  c_s_sel;
    logic [7:0]  c_s_data;
    logic [5:0]  c_m_valid, c_m_ready, c_last;
    logic [47:0] c_m_data;
    logic [1:0]  c_drop_cnt;

    stream_demux_n #(.N_CH(8), .DW(8), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .s_sel(a_s_sel), .s_data(a_s_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
        .m_data(a_m_data), .last_onehot(a_last), .drop_pulse(a_drop_pulse),
        .drop_cnt(a_drop_cnt)
    );

    stream_demux_n #(.N_CH(6), .DW(8), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_sel(b_s_sel), .s_data(b_s_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_data(b_m_data), .last_onehot(b_last), .drop_pulse(b_drop_pulse),
        .drop_cnt(b_drop_cnt)
    );

    stream_demux_n #(.N_CH(6), .DW(8), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .s_valid(c_s_valid), .s_ready(c_s_ready),
        .s_sel(c_s_sel), .s_data(c_s_data), .m_valid(c_m_valid), .m_ready(c_m_ready),
        .m_data(c_m_data), .last_onehot(c_last), .drop_pulse(c_drop_pulse),
        .drop_cnt(c_drop_cnt)
    );

    typedef struct {
        logic       vld;
        logic [2:0] sel;
        logic [7:0] data;
        logic [7:0] mrdy;
        logic       exp_srdy;
        logic [7:0] exp_mvalid;
        logic [7:0] exp_last;
        int         ch;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[14];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ch_state_t a_ch(input int ch);
        ch_state_t cs;
        cs.valid = a_m_valid[ch];
        cs.data  = a_m_data[ch*8 +: 8];
        return cs;
    endfunction

    initial begin
        ch_state_t  cs;
        logic [1:0] sat_exp[5];

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 3'(i), 8'(8'h10 + i), 8'hFF, 1'b1, 8'(1 << i), 8'(1 << i), i, 8'(8'h10 + i)};
        end
        tbl[8]  = '{1'b1, 3'd3, 8'hA5, 8'hF7, 1'b1, 8'h08, 8'h08, 3, 8'hA5};
        tbl[9]  = '{1'b1, 3'd3, 8'h5A, 8'hF7, 1'b0, 8'h08, 8'h08, 3, 8'hA5};
        tbl[10] = '{1'b1, 3'd5, 8'h33, 8'hF7, 1'b1, 8'h28, 8'h20, 5, 8'h33};
        tbl[11] = '{1'b1, 3'd3, 8'h5A, 8'hF7, 1'b0, 8'h08, 8'h20, 3, 8'hA5};
        tbl[12] = '{1'b1, 3'd3, 8'h5A, 8'hFF, 1'b1, 8'h08, 8'h08, 3, 8'h5A};
        tbl[13] = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h08, 3, 8'h5A};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        a_s_valid = 1'b0; a_s_sel = '0; a_s_data = '0; a_m_ready = '0;
        b_s_valid = 1'b0; b_s_sel = '0; b_s_data = '0; b_m_ready = '0;
        c_s_valid = 1'b0; c_s_sel = '0; c_s_data = '0; c_m_ready = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst a_m_valid",  64'(a_m_valid),    64'(0));
        check("rst a_m_data",   a_m_data,          64'(0));
        check("rst a_last",     64'(a_last),       64'(0));
        check("rst a_drop_pls", 64'(a_drop_pulse), 64'(0));
        check("rst a_drop_cnt", 64'(a_drop_cnt),   64'(0));
        check("rst b_drop_cnt", 64'(b_drop_cnt),   64'(0));
        check("rst c_drop_cnt", 64'(c_drop_cnt),   64'(0));
        rst_n = 1'b1;
        tick();

        // Streaming, stall / back-pressure and head-of-line independence on instance A
        for (int i = 0; i < 14; i++) begin
            a_s_valid = tbl[i].vld;
            a_s_sel   = tbl[i].sel;
            a_s_data  = tbl[i].data;
            a_m_ready = tbl[i].mrdy;
            #1;
            check($sformatf("v%0d s_ready", i), 64'(a_s_ready), 64'(tbl[i].exp_srdy));
            tick();
            cs = a_ch(tbl[i].ch);
            check($sformatf("v%0d m_valid", i), 64'(a_m_valid), 64'(tbl[i].exp_mvalid));
            check($sformatf("v%0d last", i),    64'(a_last),    64'(tbl[i].exp_last));
            check($sformatf("v%0d ch%0d data", i, tbl[i].ch), 64'(cs.data), 64'(tbl[i].exp_data));
            check($sformatf("v%0d drop_pulse", i), 64'(a_drop_pulse), 64'(0));
        end
        check("a drop_cnt idle", 64'(a_drop_cnt), 64'(0));

        // Out-of-range drops on instance B
        b_s_valid = 1'b1; b_s_sel = 3'd6; b_s_data = 8'hEE;
        #1;
        check("b sel6 s_ready", 64'(b_s_ready), 64'(1));
        tick();
        check("b sel6 pulse", 64'(b_drop_pulse), 64'(1));
        check("b sel6 cnt",   64'(b_drop_cnt),   64'(1));
        b_s_sel = 3'd7;
        #1;
        check("b sel7 s_ready", 64'(b_s_ready), 64'(1));
        tick();
        check("b sel7 pulse",   64'(b_drop_pulse), 64'(1));
        check("b sel7 cnt",     64'(b_drop_cnt),   64'(2));
        check("b sel7 m_valid", 64'(b_m_valid),    64'(0));
        check("b sel7 last",    64'(b_last),       64'(0));
        b_s_valid = 1'b0;
        tick();
        check("b idle pulse", 64'(b_drop_pulse), 64'(0));
        check("b idle cnt",   64'(b_drop_cnt),   64'(2));

        // Stalled lane 5 must not stall an out-of-range word
        b_s_valid = 1'b1; b_s_sel = 3'd5; b_s_data = 8'h77;
        tick();
        check("b ch5 m_valid", 64'(b_m_valid), 64'(6'h20));
        check("b ch5 data",    64'(b_m_data[40 +: 8]), 64'(8'h77));
        check("b ch5 pulse",   64'(b_drop_pulse), 64'(0));
        #1;
        check("b ch5 stall s_ready", 64'(b_s_ready), 64'(0));
        b_s_sel = 3'd7;
        #1;
        check("b oor under stall s_ready", 64'(b_s_ready), 64'(1));
        tick();
        check("b oor under stall cnt",     64'(b_drop_cnt), 64'(3));
        check("b oor under stall m_valid", 64'(b_m_valid),  64'(6'h20));
        check("b oor under stall last",    64'(b_last),     64'(6'h20));
        b_s_valid = 1'b0;

        // Saturating 2-bit drop counter on instance C
        c_s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            c_s_sel = (k % 2 == 1) ? 3'd7 : 3'd6;
            tick();
            check($sformatf("c sat cnt %0d", k), 64'(c_drop_cnt), 64'(sat_exp[k]));
        end
        check("c sat m_valid", 64'(c_m_valid), 64'(0));
        c_s_valid = 1'b0;
        tick();
        check("c sat hold", 64'(c_drop_cnt), 64'(3));

        // Asynchronous reset mid-cycle with lanes 1 and 2 holding words
        a_m_ready = 8'h00;
        a_s_valid = 1'b1; a_s_sel = 3'd1; a_s_data = 8'h11;
        tick();
        a_s_sel = 3'd2; a_s_data = 8'h22;
        tick();
        a_s_valid = 1'b0;
        check("pre-rst a_m_valid", 64'(a_m_valid), 64'(8'h06));
        check("pre-rst a_last",    64'(a_last),    64'(8'h04));
        #3;
        rst_n = 1'b0;
        #1;
        cs = a_ch(1);
        check("async rst a_m_valid", 64'(a_m_valid),  64'(0));
        check("async rst a_last",    64'(a_last),     64'(0));
        check("async rst ch1 data",  64'(cs.data),    64'(0));
        check("async rst b_cnt",     64'(b_drop_cnt), 64'(0));
        check("async rst b_m_valid", 64'(b_m_valid),  64'(0));
        check("async rst c_cnt",     64'(c_drop_cnt), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
